// File: rtl/spi_frame_pkg.sv
// Shared frame layout and controller state encoding for the SPI frame controller.
package spi_frame_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic       write,
                                                       input logic [6:0] addr,
                                                       input logic [7:0] data);
    logic [FRAME_BITS-1:0] f;
    f                    = '0;
    f[RW_BIT]            = write;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:0]        = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period timebase: one-cycle tick every CLK_DIV clocks while enabled.
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/spi_frame_controller.sv
// SPI mode-0 initiator for 16-bit register frames: one request per handshake,
// drives ncs/sclk/copi, captures cipo, pulses done when ncs returns high.
module spi_frame_controller
  import spi_frame_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  input  logic       cipo,
  output logic [7:0] rsp_data,
  output logic       done
);

  // CS_GAP must be at least 1: the gap counter terminates on its last tick.
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
  localparam logic [4:0] GAP_LAST = 5'(CS_GAP - 1);

  state_t                state_q, state_d;
  logic                  tick;
  logic                  accept;
  logic [FRAME_BITS-1:0] tx;
  logic [7:0]            rx;
  logic [4:0]            bit_cnt;
  logic                  sclk_q, copi_q, ncs_q, done_q, ready_q;
  logic [7:0]            rsp_q;

  assign accept = req_valid && ready_q;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .enable  (state_q != ST_IDLE),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && sclk_q && bit_cnt == LAST_BIT) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_GAP;
      ST_GAP:   if (tick && bit_cnt == GAP_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      rsp_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      ready_q <= (state_d == ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tx      <= pack_frame(req_write, req_addr, req_data);
            copi_q  <= req_write;
            ncs_q   <= 1'b0;
            sclk_q  <= 1'b0;
            bit_cnt <= '0;
            rx      <= '0;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx     <= {rx[6:0], cipo};
            end else begin
              sclk_q <= 1'b0;
              // copi stays on bit0 after the final falling edge
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                tx      <= {tx[FRAME_BITS-2:0], 1'b0};
                copi_q  <= tx[FRAME_BITS-2];
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            done_q  <= 1'b1;
            rsp_q   <= rx;
            bit_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (tick) bit_cnt <= bit_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;
  assign ncs       = ncs_q;
  assign done      = done_q;
  assign rsp_data  = rsp_q;

endmodule

// File: tb/tb_spi_frame_controller.sv
// Bench for spi_frame_controller: peripheral model on the bus, frame/response scoreboard, timing checks.
module tb_spi_frame_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_write, cipo;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       req_ready, sclk, copi, ncs, done;
  logic [7:0] rsp_data;

  logic       v2, w2;
  logic [6:0] a2;
  logic [7:0] d2;
  logic       ready2, sclk2, copi2, ncs2, done2;
  logic [7:0] rsp2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] exp_frame_q[$];
  logic [7:0]  exp_rsp_q[$];

  logic [7:0]  slave_rsp;
  logic [15:0] slave_word;
  logic [15:0] shreg;
  int          bits;
  int          frames_seen = 0;
  logic [7:0]  periph_regs[128];
  logic [15:0] sh2;
  int          bits2;

  spi_frame_controller #(.CLK_DIV(4), .CS_GAP(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .rsp_data(rsp_data), .done(done)
  );

  spi_frame_controller #(.CLK_DIV(2), .CS_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(ready2),
    .req_write(w2), .req_addr(a2), .req_data(d2),
    .sclk(sclk2), .copi(copi2), .ncs(ncs2), .cipo(1'b0),
    .rsp_data(rsp2), .done(done2)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // peripheral model: mode 0, captures copi on sclk rise, shifts slave_word out on cipo
  initial forever begin
    @(negedge ncs);
    bits = 0;
    shreg = '0;
    slave_word = {8'h00, slave_rsp};
    cipo = slave_word[15];
  end

  initial forever begin
    @(posedge sclk);
    if (!ncs) begin
      shreg = {shreg[14:0], copi};
      bits++;
    end
  end

  initial forever begin
    @(negedge sclk);
    if (!ncs && bits < 16) cipo = slave_word[15 - bits];
  end

  initial forever begin
    @(posedge ncs);
    if (bits == 16) begin
      frames_seen++;
      if (shreg[15]) periph_regs[shreg[14:8]] = shreg[7:0];
      checks++;
      if (exp_frame_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected got=%h want=none", shreg);
      end else begin
        logic [15:0] e;
        e = exp_frame_q.pop_front();
        if (shreg !== e) begin
          errors++;
          $display("FAIL frame_bits got=%h want=%h", shreg, e);
        end
      end
    end
    bits = 0;
  end

  // response scoreboard
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      checks++;
      if (exp_rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got=%h want=none", rsp_data);
      end else begin
        logic [7:0] e;
        e = exp_rsp_q.pop_front();
        if (rsp_data !== e) begin
          errors++;
          $display("FAIL rsp_data got=%h want=%h", rsp_data, e);
        end
      end
    end
  end

  initial forever begin
    @(negedge ncs2);
    bits2 = 0;
    sh2 = '0;
  end

  initial forever begin
    @(posedge sclk2);
    if (!ncs2) begin
      sh2 = {sh2[14:0], copi2};
      bits2++;
    end
  end

  // driver tasks
  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got=%b want=1", req_ready);
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    exp_frame_q.push_back({w, a, d});
    exp_rsp_q.push_back(slave_rsp);
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_frame(input int acc, output int first_low, output int last_low,
                            output int done_rel, output int ready_rel);
    int rel;
    first_low = -1; last_low = -1; done_rel = -1; ready_rel = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rel = cyc - acc + 1;
      if (!ncs) begin
        if (first_low < 0) first_low = rel;
        last_low = rel;
      end
      if (done && done_rel < 0) done_rel = rel;
      if (req_ready) begin
        ready_rel = rel;
        break;
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (ncs !== 1'b1)       begin errors++; $display("FAIL reset_ncs got=%b want=1", ncs); end
    if (sclk !== 1'b0)      begin errors++; $display("FAIL reset_sclk got=%b want=0", sclk); end
    if (copi !== 1'b0)      begin errors++; $display("FAIL reset_copi got=%b want=0", copi); end
    if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp got=%h want=00", rsp_data); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_timing();
    int acc, fl, ll, dr, rr;
    slave_rsp = 8'($urandom_range(1, 255));
    send(1'b1, 7'h00, 8'hFF, acc);
    wait_frame(acc, fl, ll, dr, rr);
    checks += 4;
    if (fl != 1)   begin errors++; $display("FAIL wr_first_low got=%0d want=1", fl); end
    if (ll != 132) begin errors++; $display("FAIL wr_last_low got=%0d want=132", ll); end
    if (dr != 133) begin errors++; $display("FAIL wr_done_cycle got=%0d want=133", dr); end
    if (rr != 141) begin errors++; $display("FAIL wr_ready_cycle got=%0d want=141", rr); end
  endtask

  task automatic test_loopback();
    int acc, fl, ll, dr, rr;
    slave_rsp = 8'h5A;
    send(1'b1, 7'h00, 8'hA5, acc);
    wait_frame(acc, fl, ll, dr, rr);
    send(1'b1, 7'h04, 8'h80, acc);
    wait_frame(acc, fl, ll, dr, rr);
    send(1'b0, 7'h04, 8'h11, acc);
    wait_frame(acc, fl, ll, dr, rr);
    checks += 2;
    if (periph_regs[0] !== 8'hA5) begin errors++; $display("FAIL loop_reg00 got=%h want=a5", periph_regs[0]); end
    if (periph_regs[4] !== 8'h80) begin errors++; $display("FAIL loop_reg04 got=%h want=80", periph_regs[4]); end
  endtask

  task automatic test_read_response();
    int acc, fl, ll, dr, rr;
    slave_rsp = 8'h3C;
    send(1'b0, 7'h12, 8'h00, acc);
    wait_frame(acc, fl, ll, dr, rr);
    checks++;
    if (rsp_data !== 8'h3C) begin errors++; $display("FAIL read_rsp_hold got=%h want=3c", rsp_data); end
  endtask

  task automatic test_back_to_back();
    int acc, rel, k, run, min_gap, start_frames;
    int rdy[3];
    logic [6:0] a;
    logic [7:0] d;
    a = 7'($urandom_range(0, 127));
    d = 8'($urandom_range(0, 255));
    slave_rsp = 8'($urandom_range(0, 255));
    start_frames = frames_seen;
    rdy = '{-1, -1, -1};
    for (int i = 0; i < 3; i++) begin
      exp_frame_q.push_back({1'b1, a, d});
      exp_rsp_q.push_back(slave_rsp);
    end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_data = d;
    @(posedge clk);
    #1;
    acc = cyc;
    k = 0; run = 0; min_gap = 1000;
    for (int i = 0; i < 600 && k < 3; i++) begin
      @(negedge clk);
      rel = cyc - acc + 1;
      if (ncs) run++;
      else begin
        if (run > 0 && run < min_gap) min_gap = run;
        run = 0;
      end
      if (req_ready) begin
        rdy[k] = rel;
        k++;
        if (k == 3) req_valid = 1'b0;
      end
    end
    repeat (20) @(negedge clk);
    checks += 5;
    if (rdy[0] != 141) begin errors++; $display("FAIL b2b_ready1 got=%0d want=141", rdy[0]); end
    if (rdy[1] != 282) begin errors++; $display("FAIL b2b_ready2 got=%0d want=282", rdy[1]); end
    if (rdy[2] != 423) begin errors++; $display("FAIL b2b_ready3 got=%0d want=423", rdy[2]); end
    if (frames_seen - start_frames != 3) begin
      errors++; $display("FAIL b2b_frames got=%0d want=3", frames_seen - start_frames);
    end
    if (min_gap < 8) begin errors++; $display("FAIL b2b_gap got=%0d want>=8", min_gap); end
  endtask

  task automatic test_reset_mid_frame();
    int acc, fl, ll, dr, rr, dones;
    logic [15:0] junk_f;
    logic [7:0]  junk_r;
    slave_rsp = 8'hC3;
    send(1'b1, 7'h33, 8'h44, acc);
    while (cyc - acc + 1 < 60) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 3;
    if (ncs !== 1'b1)       begin errors++; $display("FAIL mid_rst_ncs got=%b want=1", ncs); end
    if (sclk !== 1'b0)      begin errors++; $display("FAIL mid_rst_sclk got=%b want=0", sclk); end
    if (rsp_data !== 8'h00) begin errors++; $display("FAIL mid_rst_rsp got=%h want=00", rsp_data); end
    junk_f = exp_frame_q.pop_front();
    junk_r = exp_rsp_q.pop_front();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL mid_rst_done got=%0d want=0", dones); end
    slave_rsp = 8'h96;
    send(1'b1, 7'h55, 8'h0F, acc);
    wait_frame(acc, fl, ll, dr, rr);
    checks++;
    if (dr != 133) begin errors++; $display("FAIL post_rst_done got=%0d want=133", dr); end
  endtask

  task automatic test_div2();
    int acc, rel, dr, rr;
    dr = -1; rr = -1;
    @(negedge clk);
    v2 = 1'b1; w2 = 1'b1; a2 = 7'h00; d2 = 8'hFF;
    @(posedge clk);
    #1;
    acc = cyc;
    v2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rel = cyc - acc + 1;
      if (done2 && dr < 0) dr = rel;
      if (ready2) begin
        rr = rel;
        break;
      end
    end
    checks += 4;
    if (dr != 67)         begin errors++; $display("FAIL div2_done got=%0d want=67", dr); end
    if (rr != 71)         begin errors++; $display("FAIL div2_ready got=%0d want=71", rr); end
    if (sh2 !== 16'h80FF) begin errors++; $display("FAIL div2_bits got=%h want=80ff", sh2); end
    if (bits2 != 16)      begin errors++; $display("FAIL div2_count got=%0d want=16", bits2); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    v2 = 1'b0; w2 = 1'b0; a2 = '0; d2 = '0;
    cipo = 1'b0; slave_rsp = 8'h00; slave_word = '0; shreg = '0; bits = 0;
    sh2 = '0; bits2 = 0;
    for (int i = 0; i < 128; i++) periph_regs[i] = 8'h00;
    test_reset();
    test_write_timing();
    test_loopback();
    test_read_response();
    test_back_to_back();
    test_reset_mid_frame();
    test_div2();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_frame_q.size() != 0 || exp_rsp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", exp_frame_q.size(), exp_rsp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
